// File: rtl/fp32_wb_arbiter_if.sv
// Write-back bus bundle for fp32_wb_arbiter: two producer handshakes, the
// register-file write port, idle status and the issue-side hazard query.
interface fp32_wb_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a_rd;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_rd;
    logic [DW-1:0] b_data;
    logic          wen;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          idle;
    logic          issue_en;
    logic [AW-1:0] issue_rd;
    logic [AW-1:0] rs_a;
    logic [AW-1:0] rs_b;
    logic          hazard;

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output issue_en, issue_rd, rs_a, rs_b,
        input  a_ready, b_ready, wen, wa, wd, idle, hazard
    );

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  issue_en, issue_rd, rs_a, rs_b,
        output a_ready, b_ready, wen, wa, wd, idle, hazard
    );
endinterface

// File: rtl/fp32_wb_arbiter.sv
// Merges FPU pipe A (add/sub) and pipe B (mul/div) results into one register-file
// write port via per-source FIFOs and round-robin drain. Optional FP32_WB_SCOREBOARD_EN.
module fp32_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic               clock,
    input  logic               reset,
    fp32_wb_arbiter_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + DW;

    // Index 0 is source A, index 1 is source B; each entry is {rd, data}.
    logic [EW-1:0] mem_r  [2][DEPTH];
    logic [PW-1:0] wptr_r [2];
    logic [PW-1:0] rptr_r [2];
    logic [CW-1:0] cnt_r  [2];
    logic [EW-1:0] din_s  [2];
    logic [EW-1:0] head_s [2];
    logic [1:0]    valid_s;
    logic [1:0]    ready_s;
    logic [1:0]    push_s;
    logic [1:0]    ne_s;
    logic [1:0]    grant_s;
    logic [EW-1:0] ghead_s;
    logic [AW-1:0] grd_s;
    logic          rr_r;
    logic          rr_nxt_s;
    logic          wen_r;
    logic [AW-1:0] wa_r;
    logic [DW-1:0] wd_r;

    // Per-source FIFO status and push qualification
    always_comb begin
        valid_s = {bus.b_valid, bus.a_valid};
        din_s[0] = {bus.a_rd, bus.a_data};
        din_s[1] = {bus.b_rd, bus.b_data};
        for (int i = 0; i < 2; i++) begin
            ready_s[i] = (cnt_r[i] != CW'(DEPTH));
            ne_s[i]    = (cnt_r[i] != {CW{1'b0}});
            push_s[i]  = valid_s[i] & ready_s[i];
            head_s[i]  = mem_r[i][rptr_r[i]];
        end
    end

    // Round-robin grant; the pointer always moves to the side not just served
    always_comb begin
        grant_s  = 2'b00;
        rr_nxt_s = rr_r;
        if (ne_s == 2'b11) begin
            grant_s  = rr_r ? 2'b10 : 2'b01;
            rr_nxt_s = ~rr_r;
        end else if (ne_s[0]) begin
            grant_s  = 2'b01;
            rr_nxt_s = 1'b1;
        end else if (ne_s[1]) begin
            grant_s  = 2'b10;
            rr_nxt_s = 1'b0;
        end else begin
            grant_s  = 2'b00;
            rr_nxt_s = rr_r;
        end
        ghead_s = grant_s[1] ? head_s[1] : head_s[0];
        grd_s   = ghead_s[EW-1 -: AW];
    end

    // FIFO storage; entries are only read once counted, so no reset needed
    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (push_s[i]) begin
                mem_r[i][wptr_r[i]] <= din_s[i];
            end
        end
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                wptr_r[i] <= {PW{1'b0}};
                rptr_r[i] <= {PW{1'b0}};
                cnt_r[i]  <= {CW{1'b0}};
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push_s[i]) begin
                    wptr_r[i] <= wptr_r[i] + PW'(1);
                end
                if (grant_s[i]) begin
                    rptr_r[i] <= rptr_r[i] + PW'(1);
                end
                case ({push_s[i], grant_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + CW'(1);
                    2'b01:   cnt_r[i] <= cnt_r[i] - CW'(1);
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
        end
    end

    // Write port register; rd==0 entries are consumed without a write
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_r  <= 1'b0;
            wen_r <= 1'b0;
            wa_r  <= {AW{1'b0}};
            wd_r  <= {DW{1'b0}};
        end else begin
            rr_r <= rr_nxt_s;
            if ((grant_s != 2'b00) && (grd_s != {AW{1'b0}})) begin
                wen_r <= 1'b1;
                wa_r  <= grd_s;
                wd_r  <= ghead_s[DW-1:0];
            end else begin
                wen_r <= 1'b0;
            end
        end
    end

    assign bus.a_ready = ready_s[0];
    assign bus.b_ready = ready_s[1];
    assign bus.wen     = wen_r;
    assign bus.wa      = wa_r;
    assign bus.wd      = wd_r;
    assign bus.idle    = ~ne_s[0] & ~ne_s[1] & ~wen_r;

`ifdef FP32_WB_SCOREBOARD_EN
    localparam int NR = 1 << AW;
    logic [NR-1:0] busy_r;
    logic          haz_a_s;
    logic          haz_b_s;

    // In-flight tracking: write-back clears, a same-edge issue re-sets (set wins)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_r <= {NR{1'b0}};
        end else begin
            if (wen_r) begin
                busy_r[wa_r] <= 1'b0;
            end
            if (bus.issue_en && (bus.issue_rd != {AW{1'b0}})) begin
                busy_r[bus.issue_rd] <= 1'b1;
            end
        end
    end

    // A register being written this cycle is bypassed by the regfile
    always_comb begin
        haz_a_s = busy_r[bus.rs_a] & (bus.rs_a != {AW{1'b0}})
                  & ~(wen_r & (wa_r == bus.rs_a));
        haz_b_s = busy_r[bus.rs_b] & (bus.rs_b != {AW{1'b0}})
                  & ~(wen_r & (wa_r == bus.rs_b));
    end

    assign bus.hazard = haz_a_s | haz_b_s;
`else
    logic unused_s;
    assign unused_s   = ^{bus.issue_en, bus.issue_rd, bus.rs_a, bus.rs_b};
    assign bus.hazard = 1'b0;
`endif

endmodule

// File: tb/tb_fp32_wb_arbiter.sv
// Randomized bench for fp32_wb_arbiter against a queue-based model of the
// write-back merge (and the in-flight scoreboard when FP32_WB_SCOREBOARD_EN).
module tb_fp32_wb_arbiter;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    logic clock;
    logic reset;
    int   nvec;
    int   nerr;

    fp32_wb_arbiter_if #(.AW(5), .DW(32)) bus ();

    fp32_wb_arbiter #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    ent_t        qa[$];
    ent_t        qb[$];
    bit          next_is_b;
    bit          exp_wen;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
    bit          busy[32];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_hazard();
        bit h;
        h = 1'b0;
`ifdef FP32_WB_SCOREBOARD_EN
        if (bus.rs_a != 5'd0 && busy[bus.rs_a] && !(exp_wen && exp_wa == bus.rs_a)) h = 1'b1;
        if (bus.rs_b != 5'd0 && busy[bus.rs_b] && !(exp_wen && exp_wa == bus.rs_b)) h = 1'b1;
`endif
        return h;
    endfunction

    task automatic model_clear();
        qa.delete();
        qb.delete();
        next_is_b = 1'b0;
        exp_wen   = 1'b0;
        exp_wa    = 5'd0;
        exp_wd    = 32'd0;
        for (int i = 0; i < 32; i++) busy[i] = 1'b0;
    endtask

    task automatic quiet_inputs();
        bus.a_valid  = 1'b0;
        bus.b_valid  = 1'b0;
        bus.issue_en = 1'b0;
    endtask

    // One clock: check outputs against the model, advance the model, cross the edge
    task automatic step();
        bit   pa, pb, ga, gb;
        ent_t e;
        #2;
        check_eq("a_ready", bus.a_ready, qa.size() < DEPTH);
        check_eq("b_ready", bus.b_ready, qb.size() < DEPTH);
        check_eq("wen", bus.wen, exp_wen);
        if (exp_wen) begin
            check_eq("wa", bus.wa, exp_wa);
            check_eq("wd", bus.wd, exp_wd);
        end
        check_eq("idle", bus.idle, qa.size() == 0 && qb.size() == 0 && !exp_wen);
        check_eq("hazard", bus.hazard, model_hazard());
        pa = bus.a_valid && (qa.size() < DEPTH);
        pb = bus.b_valid && (qb.size() < DEPTH);
        ga = 1'b0;
        gb = 1'b0;
        if (qa.size() > 0 && qb.size() > 0) begin
            if (next_is_b) gb = 1'b1; else ga = 1'b1;
        end else if (qa.size() > 0) begin
            ga = 1'b1;
        end else if (qb.size() > 0) begin
            gb = 1'b1;
        end
        if (ga || gb) next_is_b = ga;
        if (exp_wen) busy[exp_wa] = 1'b0;
        if (bus.issue_en && bus.issue_rd != 5'd0) busy[bus.issue_rd] = 1'b1;
        exp_wen = 1'b0;
        if (ga || gb) begin
            e = ga ? qa.pop_front() : qb.pop_front();
            if (e.rd != 5'd0) begin
                exp_wen = 1'b1;
                exp_wa  = e.rd;
                exp_wd  = e.d;
            end
        end
        if (pa) qa.push_back('{rd: bus.a_rd, d: bus.a_data});
        if (pb) qb.push_back('{rd: bus.b_rd, d: bus.b_data});
        @(posedge clock);
        #1;
    endtask

    task automatic mid_reset();
        quiet_inputs();
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_wen", bus.wen, 1'b0);
        check_eq("rst_idle", bus.idle, 1'b1);
        check_eq("rst_a_ready", bus.a_ready, 1'b1);
        check_eq("rst_b_ready", bus.b_ready, 1'b1);
        check_eq("rst_hazard", bus.hazard, 1'b0);
        model_clear();
        @(posedge clock);
        #3;
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int ia, ib;
        bit acc_a, acc_b;
        nvec = 0;
        nerr = 0;
        model_clear();
        quiet_inputs();
        bus.a_rd = 5'd0; bus.a_data = 32'd0;
        bus.b_rd = 5'd0; bus.b_data = 32'd0;
        bus.issue_rd = 5'd0; bus.rs_a = 5'd0; bus.rs_b = 5'd0;
        reset = 1'b0;
        #2;
        check_eq("por_wen", bus.wen, 1'b0);
        check_eq("por_wa", bus.wa, 5'd0);
        check_eq("por_wd", bus.wd, 32'd0);
        check_eq("por_idle", bus.idle, 1'b1);
        check_eq("por_a_ready", bus.a_ready, 1'b1);
        #10;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Single A result, two-clock latency
        bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'h3F80_0000;
        step();
        quiet_inputs();
        step();
        check_eq("lat_wen", bus.wen, 1'b1);
        check_eq("lat_wa", bus.wa, 5'd5);
        check_eq("lat_wd", bus.wd, 32'h3F80_0000);
        step();

        // Both sources stream rd 1..8; B backs up to full
        ia = 0; ib = 0;
        for (int c = 0; c < 40 && (ia < 8 || ib < 8); c++) begin
            bus.a_valid = (ia < 8); bus.a_rd = 5'(ia + 1); bus.a_data = 32'hA000_0000 + 32'(ia);
            bus.b_valid = (ib < 8); bus.b_rd = 5'(ib + 1); bus.b_data = 32'hB000_0000 + 32'(ib);
            acc_a = bus.a_valid && (qa.size() < DEPTH);
            acc_b = bus.b_valid && (qb.size() < DEPTH);
            step();
            if (acc_a) ia++;
            if (acc_b) ib++;
        end
        check_eq("stream_all_a", 32'(ia), 32'd8);
        check_eq("stream_all_b", 32'(ib), 32'd8);
        quiet_inputs();
        for (int c = 0; c < 20; c++) step();

        // rd==0 is dropped
        bus.a_valid = 1'b1; bus.a_rd = 5'd0; bus.a_data = 32'hDEAD_BEEF;
        step();
        quiet_inputs();
        for (int c = 0; c < 3; c++) step();
        check_eq("drop_idle", bus.idle, 1'b1);

        // Reset with writes queued
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.a_rd = 5'(c + 10); bus.a_data = $urandom;
            bus.b_rd = 5'(c + 20); bus.b_data = $urandom;
            step();
        end
        mid_reset();

`ifdef FP32_WB_SCOREBOARD_EN
        bus.issue_en = 1'b1; bus.issue_rd = 5'd7;
        step();
        bus.issue_en = 1'b0; bus.rs_a = 5'd7;
        #2;
        check_eq("sb_haz_set", bus.hazard, 1'b1);
        bus.a_valid = 1'b1; bus.a_rd = 5'd7; bus.a_data = 32'h4000_0000;
        step();
        bus.a_valid = 1'b0;
        step();
        #2;
        check_eq("sb_haz_bypass", bus.hazard, 1'b0);
        bus.issue_en = 1'b1; bus.issue_rd = 5'd7;
        step();
        bus.issue_en = 1'b0;
        #2;
        check_eq("sb_set_wins", bus.hazard, 1'b1);
        step();
`endif

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            bus.a_valid  = $urandom_range(0, 1);
            bus.a_rd     = 5'($urandom_range(0, 31));
            bus.a_data   = $urandom;
            bus.b_valid  = $urandom_range(0, 1);
            bus.b_rd     = 5'($urandom_range(0, 31));
            bus.b_data   = $urandom;
            bus.issue_en = ($urandom_range(0, 3) == 0);
            bus.issue_rd = 5'($urandom_range(0, 31));
            bus.rs_a     = 5'($urandom_range(0, 31));
            bus.rs_b     = 5'($urandom_range(0, 31));
            step();
        end
        quiet_inputs();
        for (int c = 0; c < 3 * DEPTH + 4; c++) step();
        check_eq("drain_idle", bus.idle, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
